// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state, read-return owner tag
// and the register bundle that holds all arbiter state in one inspectable struct.
package dmem_arb_pkg;

    localparam int C_BURST_W = 4;

    typedef enum logic {
        S_CORE_PRIO = 1'b0,
        S_DBG_PRIO  = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } arb_owner_t;

    // All arbiter flops, grouped so a checker can bind to one signal.
    typedef struct packed {
        arb_state_t           state;
        logic [C_BURST_W-1:0] burst;
        arb_owner_t           owner;
        logic                 rd_pend;
    } arb_regs_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory between the core load/store port and the debug port,
// with a burst limit on core grants and a one-cycle tagged read return path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11,
    parameter int P_MAX_BURST       = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_core_req,
    input  logic                         i_core_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_core_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_core_wdata,
    output logic                         o_core_gnt,
    output logic                         o_core_stall,
    output logic                         o_core_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_core_rdata,
    input  logic                         i_dbg_req,
    input  logic                         i_dbg_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dbg_wdata,
    output logic                         o_dbg_gnt,
    output logic                         o_dbg_rvalid,
    output logic [P_DATA_WIDTH-1:0]      o_dbg_rdata,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [P_DMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata
);

    localparam logic [C_BURST_W-1:0] C_MAX_BURST = C_BURST_W'(P_MAX_BURST);
    localparam logic [C_BURST_W-1:0] C_ONE       = C_BURST_W'(1);

    arb_regs_t arb_q;
    arb_regs_t arb_d;
    logic      core_gnt;
    logic      dbg_gnt;
    logic      core_rvalid;
    logic      dbg_rvalid;

    // Handshake: a port's command is accepted in exactly the cycle its gnt is high
    // (req & gnt); a request without gnt must be held stable into the next cycle.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!i_rst) begin
            if (arb_q.state == S_CORE_PRIO) begin
                core_gnt = i_core_req;
                dbg_gnt  = i_dbg_req & ~i_core_req;
            end else begin
                dbg_gnt  = i_dbg_req;
                core_gnt = i_core_req & ~i_dbg_req;
            end
        end
    end

    always_comb begin
        arb_d = arb_q;

        if (!i_dbg_req || dbg_gnt) begin
            arb_d.burst = '0;
        end else if (core_gnt && arb_q.burst != C_MAX_BURST) begin
            arb_d.burst = arb_q.burst + C_ONE;
        end

        if (arb_q.state == S_CORE_PRIO) begin
            if (core_gnt && i_dbg_req && arb_d.burst == C_MAX_BURST) begin
                arb_d.state = S_DBG_PRIO;
            end
        end else if (dbg_gnt || !i_dbg_req) begin
            arb_d.state = S_CORE_PRIO;
        end

        // The tag only moves on a granted read; writes leave it alone.
        arb_d.rd_pend = (core_gnt & ~i_core_we) | (dbg_gnt & ~i_dbg_we);
        if (dbg_gnt && !i_dbg_we) begin
            arb_d.owner = OWN_DBG;
        end else if (core_gnt && !i_core_we) begin
            arb_d.owner = OWN_CORE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            arb_q.state   <= S_CORE_PRIO;
            arb_q.burst   <= '0;
            arb_q.owner   <= OWN_CORE;
            arb_q.rd_pend <= 1'b0;
        end else begin
            arb_q <= arb_d;
        end
    end

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (core_gnt) begin
            o_mem_we    = i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
        end else if (dbg_gnt) begin
            o_mem_we    = i_dbg_we;
            o_mem_addr  = i_dbg_addr;
            o_mem_wdata = i_dbg_wdata;
        end
    end

    // A return still pending when reset arrives is dropped, not delivered.
    assign core_rvalid = arb_q.rd_pend & (arb_q.owner == OWN_CORE) & ~i_rst;
    assign dbg_rvalid  = arb_q.rd_pend & (arb_q.owner == OWN_DBG) & ~i_rst;

    assign o_mem_en      = core_gnt | dbg_gnt;
    assign o_core_gnt    = core_gnt;
    assign o_dbg_gnt     = dbg_gnt;
    assign o_core_stall  = i_core_req & ~core_gnt & ~i_rst;
    assign o_core_rvalid = core_rvalid;
    assign o_dbg_rvalid  = dbg_rvalid;
    assign o_core_rdata  = core_rvalid ? i_mem_rdata : '0;
    assign o_dbg_rdata   = dbg_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: synchronous memory model, read-return scoreboard and
// one task per scenario.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, dbg_req, dbg_we;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic          core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_on = 1'b0;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    logic [DW-1:0] shadow    [0:(1<<AW)-1];
    logic [DW-1:0] core_exp_q [$];
    logic [DW-1:0] dbg_exp_q  [$];
    logic          core_pend = 1'b0;
    logic          dbg_pend  = 1'b0;
    logic          mon_exp_rv;
    logic [DW-1:0] mon_exp_data;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .P_DATA_WIDTH(DW), .P_DMEM_ADDR_WIDTH(AW), .P_MAX_BURST(MB)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .o_core_gnt(core_gnt), .o_core_stall(core_stall),
        .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
        .i_dbg_wdata(dbg_wdata), .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid),
        .o_dbg_rdata(dbg_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory: read data appears the cycle after the command.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    // Scoreboard: expected read data is pushed on a granted read (from the stimulus
    // address) and popped when the return is due one cycle later.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_exp_rv = core_pend && !rst;
            n_cmp = n_cmp + 1;
            if (core_rvalid !== mon_exp_rv) begin
                n_bad = n_bad + 1;
                $display("FAIL sb_core_rvalid got=%b exp=%b t=%0t", core_rvalid, mon_exp_rv, $time);
            end
            if (core_pend && core_exp_q.size() > 0) begin
                mon_exp_data = core_exp_q.pop_front();
                if (mon_exp_rv) begin
                    n_cmp = n_cmp + 1;
                    if (core_rdata !== mon_exp_data) begin
                        n_bad = n_bad + 1;
                        $display("FAIL sb_core_rdata got=%h exp=%h t=%0t", core_rdata, mon_exp_data, $time);
                    end
                end
            end else if (!core_pend) begin
                n_cmp = n_cmp + 1;
                if (core_rdata !== '0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL sb_core_rdata_idle got=%h exp=0 t=%0t", core_rdata, $time);
                end
            end

            mon_exp_rv = dbg_pend && !rst;
            n_cmp = n_cmp + 1;
            if (dbg_rvalid !== mon_exp_rv) begin
                n_bad = n_bad + 1;
                $display("FAIL sb_dbg_rvalid got=%b exp=%b t=%0t", dbg_rvalid, mon_exp_rv, $time);
            end
            if (dbg_pend && dbg_exp_q.size() > 0) begin
                mon_exp_data = dbg_exp_q.pop_front();
                if (mon_exp_rv) begin
                    n_cmp = n_cmp + 1;
                    if (dbg_rdata !== mon_exp_data) begin
                        n_bad = n_bad + 1;
                        $display("FAIL sb_dbg_rdata got=%h exp=%h t=%0t", dbg_rdata, mon_exp_data, $time);
                    end
                end
            end else if (!dbg_pend) begin
                n_cmp = n_cmp + 1;
                if (dbg_rdata !== '0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL sb_dbg_rdata_idle got=%h exp=0 t=%0t", dbg_rdata, $time);
                end
            end

            core_pend = 1'b0;
            dbg_pend  = 1'b0;
            if (!rst && core_gnt === 1'b1) begin
                if (core_we) shadow[core_addr] = core_wdata;
                else begin
                    core_exp_q.push_back(shadow[core_addr]);
                    core_pend = 1'b1;
                end
            end
            if (!rst && dbg_gnt === 1'b1) begin
                if (dbg_we) shadow[dbg_addr] = dbg_wdata;
                else begin
                    dbg_exp_q.push_back(shadow[dbg_addr]);
                    dbg_pend = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'd5; core_wdata = '0;
        dbg_req = 1'b1;  dbg_we = 1'b1;  dbg_addr = 11'd6;  dbg_wdata = 32'hDEAD;
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp = n_cmp + 1;
            if ({core_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, core_stall, core_rvalid, dbg_rvalid} !== '0) begin
                n_bad = n_bad + 1;
                $display("FAIL reset_outs got=%b%b%b%b_%h_%h_%b%b%b exp=all0", core_gnt, dbg_gnt, mem_en,
                         mem_we, mem_addr, mem_wdata, core_stall, core_rvalid, dbg_rvalid);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic test_idle(input int cycles);
        core_req = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_cmp = n_cmp + 1;
            if ({core_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata, core_stall, core_rvalid, dbg_rvalid} !== '0) begin
                n_bad = n_bad + 1;
                $display("FAIL idle_outs got=%b%b%b%b_%h_%h_%b%b%b exp=all0", core_gnt, dbg_gnt, mem_en,
                         mem_we, mem_addr, mem_wdata, core_stall, core_rvalid, dbg_rvalid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_core_read();
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'd100;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_gnt, mem_en, mem_we, mem_addr, core_stall} !== {1'b1, 1'b1, 1'b0, 11'd100, 1'b0}) begin
            n_bad = n_bad + 1;
            $display("FAIL core_read_cmd got=%b%b%b_%0d_%b exp=110_100_0", core_gnt, mem_en, mem_we, mem_addr, core_stall);
        end
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_rvalid, core_rdata, dbg_rvalid} !== {1'b1, 32'd25, 1'b0}) begin
            n_bad = n_bad + 1;
            $display("FAIL core_read_ret got=%b_%0d_%b exp=1_25_0", core_rvalid, core_rdata, dbg_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dbg_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'd96; dbg_wdata = 32'd7;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({dbg_gnt, core_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 1'b1, 11'd96, 32'd7}) begin
            n_bad = n_bad + 1;
            $display("FAIL dbg_write_cmd got=%b%b%b%b_%0d_%0d exp=1011_96_7", dbg_gnt, core_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL dbg_write_no_rvalid got=%b%b exp=00", core_rvalid, dbg_rvalid);
        end
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd96;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'd7}) begin
            n_bad = n_bad + 1;
            $display("FAIL dbg_readback got=%b_%0d exp=1_7", dbg_rvalid, dbg_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention(input int cycles);
        logic exp_core;
        core_req = 1'b1; core_we = 1'b0;
        core_addr = AW'($urandom_range(200, 1000)); core_wdata = $urandom;
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = AW'($urandom_range(200, 1000)); dbg_wdata = $urandom;
        for (int c = 0; c < cycles; c++) begin
            exp_core = ((c % (MB + 1)) != MB);
            @(negedge clk);
            n_cmp = n_cmp + 1;
            if ({core_gnt, dbg_gnt, core_stall} !== {exp_core, !exp_core, !exp_core}) begin
                n_bad = n_bad + 1;
                $display("FAIL burst_pattern c=%0d got=%b%b%b exp=%b%b%b", c, core_gnt, dbg_gnt, core_stall,
                         exp_core, !exp_core, !exp_core);
            end
            @(posedge clk); #1;
            if (exp_core) begin
                core_we = 1'($urandom_range(0, 1)); core_addr = AW'($urandom_range(200, 1000)); core_wdata = $urandom;
            end else begin
                dbg_we = 1'($urandom_range(0, 1)); dbg_addr = AW'($urandom_range(200, 1000)); dbg_wdata = $urandom;
            end
        end
        core_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'd10;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (core_gnt !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_core_gnt got=%b exp=1", core_gnt);
        end
        @(posedge clk); #1;
        core_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd11;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_rvalid, core_rdata, dbg_gnt, dbg_rvalid} !== {1'b1, 32'hA5A5_0010, 1'b1, 1'b0}) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_first got=%b_%h_%b_%b exp=1_a5a50010_1_0", core_rvalid, core_rdata, dbg_gnt, dbg_rvalid);
        end
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({dbg_rvalid, dbg_rdata, core_rvalid} !== {1'b1, 32'h5A5A_0011, 1'b0}) begin
            n_bad = n_bad + 1;
            $display("FAIL b2b_second got=%b_%h_%b exp=1_5a5a0011_0", dbg_rvalid, dbg_rdata, core_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        core_req = 1'b1; core_we = 1'b0; core_addr = 11'd100;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (core_gnt !== 1'b1) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_mid_gnt got=%b exp=1", core_gnt);
        end
        @(posedge clk); #1;
        core_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_mid_in_reset got=%b%b exp=00", core_rvalid, dbg_rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL rst_mid_after got=%b%b exp=00", core_rvalid, dbg_rvalid);
        end
        @(posedge clk); #1;
        test_contention(MB + 1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem_model[i] = 32'h1000_0000 + DW'(i);
            shadow[i]    = 32'h1000_0000 + DW'(i);
        end
        mem_model[100] = 32'd25;         shadow[100] = 32'd25;
        mem_model[10]  = 32'hA5A5_0010;  shadow[10]  = 32'hA5A5_0010;
        mem_model[11]  = 32'h5A5A_0011;  shadow[11]  = 32'h5A5A_0011;
        mem_rdata = '0;

        test_reset();
        test_idle(2);
        test_core_read();
        test_dbg_write();
        test_idle(2);
        test_contention(3 * (MB + 1));
        test_back_to_back();
        test_reset_mid_read();
        test_idle(10);

        n_cmp = n_cmp + 1;
        if (core_exp_q.size() + dbg_exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL sb_drain got=%0d/%0d exp=0/0", core_exp_q.size(), dbg_exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
